// File: rtl/mccoy_pkg.sv
// mccoy_pkg: shared types and constants for the mccoy program sequencer.
// Holds the FSM state encoding, the default instruction width and NOP word.
package mccoy_pkg;

   localparam int MCCOY_IW = 6;

   localparam logic [MCCOY_IW-1:0] MCCOY_NOP = 6'b000000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mccoy_seq_buf.sv
// mccoy_seq_buf: DEPTH x IW program register file.
// One synchronous write port, one asynchronous read port, no reset.
module mccoy_seq_buf #(
   parameter int DEPTH = 8,
   parameter int IW    = 6,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [IW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [IW-1:0] o_rdata
);

   logic [IW-1:0] r_mem [DEPTH];

   // program words are appended one per accepted handshake
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mccoy_sequencer.sv
// mccoy_sequencer: loads a short program, then replays it to a core.
// Optional single-step gating is built when MCCOY_SEQ_STEP_EN is defined.
module mccoy_sequencer
   import mccoy_pkg::*;
#(
   parameter int            DEPTH     = 8,
   parameter int            IW        = MCCOY_IW,
   parameter logic [IW-1:0] NOP_INSTR = MCCOY_NOP,
   parameter int            AW        = $clog2(DEPTH),
   parameter int            CW        = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [IW-1:0] wr_instr,
   input  logic          clear,
   input  logic          start,
   input  logic          halt,
   input  logic          loop_en,
   input  logic          step_mode,
   input  logic          step,
   output logic [IW-1:0] instr_out,
   output logic          instr_valid,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [CW-1:0] ONE  = CW'(1);

   state_t        r_state;
   state_t        w_state_nx;
   logic [CW-1:0] r_pc;
   logic [CW-1:0] w_pc_nx;
   logic [CW-1:0] r_count;
   logic [IW-1:0] r_instr;
   logic [IW-1:0] w_instr_nx;
   logic [IW-1:0] w_rd_data;
   logic [AW-1:0] w_rd_addr;
   logic          r_valid;
   logic          w_issue;
   logic          w_adv;
   logic          w_last;
   logic          w_go;
   logic          w_clr;
   logic          w_we;
   logic          w_unused_step;

`ifdef MCCOY_SEQ_STEP_EN
   assign w_adv = !step_mode || step;
   assign w_unused_step = 1'b0;
`else
   assign w_adv = 1'b1;
   assign w_unused_step = step_mode ^ step;
`endif

   // pc == count means every word has gone out this pass
   assign w_last = (r_pc == r_count);
   assign w_clr  = (r_state == IDLE) && clear;
   // clear beats start when both arrive together
   assign w_go   = (r_state == IDLE) && start && !clear
                   && (r_count != '0);

   assign w_rd_addr = (r_state == RUN && !w_last)
                      ? r_pc[AW-1:0] : '0;

   mccoy_seq_buf #(
      .DEPTH (DEPTH),
      .IW    (IW),
      .AW    (AW)
   ) u_buf (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_count[AW-1:0]),
      .i_wdata (wr_instr),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rd_data)
   );

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // next state, next pc and whether a word issues this edge
   always_comb begin
      w_state_nx = r_state;
      w_pc_nx    = r_pc;
      w_issue    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_go) begin
               w_state_nx = RUN;
               if (w_adv) begin
                  w_issue = 1'b1;
                  w_pc_nx = ONE;
               end else begin
                  w_pc_nx = '0;
               end
            end
         end
         RUN: begin
            if (halt) begin
               w_state_nx = IDLE;
               w_pc_nx    = '0;
            end else if (w_adv) begin
               if (!w_last) begin
                  w_issue = 1'b1;
                  w_pc_nx = r_pc + ONE;
               end else if (loop_en) begin
                  w_issue = 1'b1;
                  w_pc_nx = ONE;
               end else begin
                  w_state_nx = DONE;
                  w_pc_nx    = '0;
               end
            end
         end
         DONE: begin
            w_state_nx = IDLE;
            w_pc_nx    = '0;
         end
         default: begin
            w_state_nx = IDLE;
            w_pc_nx    = '0;
         end
      endcase
   end

   // status outputs, write handshake and next instruction word
   always_comb begin
      busy       = (r_state == RUN);
      done       = (r_state == DONE);
      wr_ready   = (r_state == IDLE) && (r_count < FULL)
                   && !start && !clear;
      w_we       = wr_valid && wr_ready;
      w_instr_nx = w_issue ? w_rd_data : NOP_INSTR;
   end

   // pc, issue register and load count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc    <= '0;
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
         r_count <= '0;
      end else begin
         r_pc    <= w_pc_nx;
         r_instr <= w_instr_nx;
         r_valid <= w_issue;
         if (w_clr) begin
            r_count <= '0;
         end else if (w_we) begin
            r_count <= r_count + ONE;
         end
      end
   end

   assign instr_out   = r_instr;
   assign instr_valid = r_valid;
   assign count       = r_count;

endmodule

// File: tb/tb_mccoy_sequencer.sv
// tb_mccoy_sequencer: directed vector bench for mccoy_sequencer.
// Table of per-cycle vectors plus hand sequences for full/reset/step.
module tb_mccoy_sequencer;

   logic       clk;
   logic       reset_n;
   logic       wr_valid;
   logic       wr_ready;
   logic [5:0] wr_instr;
   logic       clear;
   logic       start;
   logic       halt;
   logic       loop_en;
   logic       step_mode;
   logic       step;
   logic [5:0] instr_out;
   logic       instr_valid;
   logic       busy;
   logic       done;
   logic [3:0] count;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic       wv;
      logic [5:0] wi;
      logic       clr;
      logic       st;
      logic       hlt;
      logic       lp;
      logic       x_rdy;
      logic [5:0] x_ins;
      logic       x_val;
      logic       x_busy;
      logic       x_done;
      logic [3:0] x_cnt;
   } vec_t;

   vec_t vq[$];

   mccoy_sequencer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_instr    (wr_instr),
      .clear       (clear),
      .start       (start),
      .halt        (halt),
      .loop_en     (loop_en),
      .step_mode   (step_mode),
      .step        (step),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .busy        (busy),
      .done        (done),
      .count       (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic [5:0] ins,
                          input logic val, input logic bsy,
                          input logic dn, input logic [3:0] cnt);
      chk({nm, ".instr"}, 32'(instr_out), 32'(ins));
      chk({nm, ".valid"}, 32'(instr_valid), 32'(val));
      chk({nm, ".busy"}, 32'(busy), 32'(bsy));
      chk({nm, ".done"}, 32'(done), 32'(dn));
      chk({nm, ".count"}, 32'(count), 32'(cnt));
   endtask

   function automatic vec_t mk(
      input logic wv, input logic [5:0] wi, input logic clr,
      input logic st, input logic hlt, input logic lp,
      input logic x_rdy, input logic [5:0] x_ins, input logic x_val,
      input logic x_busy, input logic x_done, input logic [3:0] x_cnt);
      vec_t v;
      v.wv = wv; v.wi = wi; v.clr = clr; v.st = st;
      v.hlt = hlt; v.lp = lp; v.x_rdy = x_rdy; v.x_ins = x_ins;
      v.x_val = x_val; v.x_busy = x_busy; v.x_done = x_done;
      v.x_cnt = x_cnt;
      return v;
   endfunction

   task automatic idle_in();
      wr_valid = 1'b0; wr_instr = '0; clear = 1'b0;
      start = 1'b0; halt = 1'b0; loop_en = 1'b0;
   endtask

   logic [5:0] fw [8];
   localparam logic [5:0] N  = 6'b000000;
   localparam logic [5:0] WA = 6'b101010;
   localparam logic [5:0] WB = 6'b010101;

   initial begin
      // three-word replay, write during RUN, clear, empty start
      vq.push_back(mk(1, 6'b011000, 0, 0, 0, 0, 1, N, 0, 0, 0, 1));
      vq.push_back(mk(1, 6'b010110, 0, 0, 0, 0, 1, N, 0, 0, 0, 2));
      vq.push_back(mk(1, 6'b100000, 0, 0, 0, 0, 1, N, 0, 0, 0, 3));
      vq.push_back(mk(0, N, 0, 1, 0, 0, 0, 6'b011000, 1, 1, 0, 3));
      vq.push_back(mk(1, 6'b111111, 0, 0, 0, 0, 0, 6'b010110, 1, 1, 0, 3));
      vq.push_back(mk(0, N, 0, 0, 0, 0, 0, 6'b100000, 1, 1, 0, 3));
      vq.push_back(mk(0, N, 0, 0, 0, 0, 0, N, 0, 0, 1, 3));
      vq.push_back(mk(0, N, 0, 0, 0, 0, 0, N, 0, 0, 0, 3));
      vq.push_back(mk(0, N, 0, 0, 0, 0, 1, N, 0, 0, 0, 3));
      vq.push_back(mk(1, 6'b000111, 1, 0, 0, 0, 0, N, 0, 0, 0, 0));
      vq.push_back(mk(0, N, 0, 1, 0, 0, 0, N, 0, 0, 0, 0));
      vq.push_back(mk(0, N, 0, 0, 0, 0, 1, N, 0, 0, 0, 0));
      // looped two-word program, loop_en dropped before a B issue
      vq.push_back(mk(1, WA, 0, 0, 0, 0, 1, N, 0, 0, 0, 1));
      vq.push_back(mk(1, WB, 0, 0, 0, 0, 1, N, 0, 0, 0, 2));
      vq.push_back(mk(0, N, 0, 1, 0, 1, 0, WA, 1, 1, 0, 2));
      vq.push_back(mk(0, N, 0, 0, 0, 1, 0, WB, 1, 1, 0, 2));
      vq.push_back(mk(0, N, 0, 0, 0, 1, 0, WA, 1, 1, 0, 2));
      vq.push_back(mk(0, N, 0, 0, 0, 1, 0, WB, 1, 1, 0, 2));
      vq.push_back(mk(0, N, 0, 0, 0, 1, 0, WA, 1, 1, 0, 2));
      vq.push_back(mk(0, N, 0, 0, 0, 0, 0, WB, 1, 1, 0, 2));
      vq.push_back(mk(0, N, 0, 0, 0, 0, 0, N, 0, 0, 1, 2));
      vq.push_back(mk(0, N, 0, 0, 0, 0, 0, N, 0, 0, 0, 2));
      // halt on second issue cycle, then replay from word 0
      vq.push_back(mk(0, N, 1, 0, 0, 0, 0, N, 0, 0, 0, 0));
      vq.push_back(mk(1, 6'b000001, 0, 0, 0, 0, 1, N, 0, 0, 0, 1));
      vq.push_back(mk(1, 6'b000010, 0, 0, 0, 0, 1, N, 0, 0, 0, 2));
      vq.push_back(mk(1, 6'b000011, 0, 0, 0, 0, 1, N, 0, 0, 0, 3));
      vq.push_back(mk(1, 6'b000100, 0, 0, 0, 0, 1, N, 0, 0, 0, 4));
      vq.push_back(mk(0, N, 0, 1, 0, 0, 0, 6'b000001, 1, 1, 0, 4));
      vq.push_back(mk(0, N, 0, 0, 1, 0, 0, N, 0, 0, 0, 4));
      vq.push_back(mk(0, N, 0, 1, 0, 0, 0, 6'b000001, 1, 1, 0, 4));
      vq.push_back(mk(0, N, 0, 0, 0, 0, 0, 6'b000010, 1, 1, 0, 4));
      vq.push_back(mk(0, N, 0, 0, 0, 0, 0, 6'b000011, 1, 1, 0, 4));
      vq.push_back(mk(0, N, 0, 0, 0, 0, 0, 6'b000100, 1, 1, 0, 4));
      vq.push_back(mk(0, N, 0, 0, 0, 0, 0, N, 0, 0, 1, 4));
      vq.push_back(mk(0, N, 0, 0, 0, 0, 0, N, 0, 0, 0, 4));

      for (int i = 0; i < 8; i++) fw[i] = 6'(i * 5 + 2);

      reset_n = 1'b0;
      step_mode = 1'b0;
      step = 1'b0;
      idle_in();
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", N, 0, 0, 0, 0);
      chk("reset.rdy", 32'(wr_ready), 32'(1));
      #2 reset_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vq[i]) begin
         wr_valid = vq[i].wv; wr_instr = vq[i].wi;
         clear = vq[i].clr; start = vq[i].st;
         halt = vq[i].hlt; loop_en = vq[i].lp;
         #1;
         chk($sformatf("v%0d.rdy", i), 32'(wr_ready),
             32'(vq[i].x_rdy));
         @(posedge clk);
         #1;
         chk_out($sformatf("v%0d", i), vq[i].x_ins, vq[i].x_val,
                 vq[i].x_busy, vq[i].x_done, vq[i].x_cnt);
      end
      idle_in();

      // fill to DEPTH, then a ninth word must be refused
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wr_valid = 1'b1; wr_instr = fw[i];
         #1;
         chk($sformatf("fill%0d.rdy", i), 32'(wr_ready), 32'(1));
         @(posedge clk);
         #1;
         chk($sformatf("fill%0d.count", i), 32'(count), 32'(i + 1));
      end
      wr_instr = 6'b111111;
      #1;
      chk("full.rdy", 32'(wr_ready), 32'(0));
      @(posedge clk);
      #1;
      chk("full.count", 32'(count), 32'(8));
      wr_valid = 1'b0;
      start = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         chk_out($sformatf("full.iss%0d", i), fw[i], 1, 1, 0, 8);
      end
      @(posedge clk);
      #1;
      chk_out("full.done", N, 0, 0, 1, 8);
      @(posedge clk);
      #1;

      // asynchronous reset in the middle of a replay
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk_out("midrun", fw[1], 1, 1, 0, 8);
      #2 reset_n = 1'b0;
      #1;
      chk_out("arst", N, 0, 0, 0, 0);
      #2 reset_n = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk_out("arst.start", N, 0, 0, 0, 0);

`ifdef MCCOY_SEQ_STEP_EN
      // single-step: words issue only on step cycles 2 and 5
      wr_valid = 1'b1; wr_instr = WA;
      @(posedge clk);
      #1;
      wr_instr = WB;
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      step_mode = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk_out("step.c0", N, 0, 1, 0, 2);
      for (int c = 1; c <= 7; c++) begin
         step = (c == 2 || c == 5);
         @(posedge clk);
         #1;
         step = 1'b0;
         chk_out($sformatf("step.c%0d", c),
                 (c == 2) ? WA : (c == 5) ? WB : N,
                 (c == 2 || c == 5), 1, 0, 2);
      end
      halt = 1'b1;
      @(posedge clk);
      #1;
      halt = 1'b0;
      step_mode = 1'b0;
      chk_out("step.halt", N, 0, 0, 0, 2);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
